vend_dispense_arbiter: RTL and testbench
========================================

# vend_dispense_arbiter

Shares one physical dispense mechanism (motor plus half-dollar change chute) among NREQ independent vending-sale FSMs. Each sale FSM raises a dispense request once its coin total is reached. This block grants the mechanism round-robin, sequences motor-on and change-return intervals, and reports completion per requester. It sits between the sale FSMs and the actuator drivers.

## Interface
- NREQ, 4, number of requesting sale FSMs (≥2)
- DISPENSE_CYC, 8, motor-on duration in clk cycles (≥1)
- CHANGE_CYC, 4, change-chute duration in clk cycles (≥1)

- clk  in  1  clock
- reset  in  1  reset reset, synchronous, active-high; clock clk
- req  in  NREQ  level dispense request per sale FSM
- change_req  in  NREQ  requester also owes half-dollar change; sampled with req at arbitration
- grant  out  NREQ  one-hot, one-cycle pulse naming the new owner
- motor_on  out  1  dispense motor drive
- coin_out  out  1  change-chute drive
- busy  out  1  mechanism owned (any state other than IDLE)
- done  out  NREQ  one-hot, one-cycle pulse when the owner's sale completes

## Operation
- States: IDLE, DISPENSE, CHANGE, DONE.
- IDLE: if req≠0, select the first set bit searching upward from (last+1) mod NREQ, wrapping. Register owner and change flag = change_req[owner]. Go to DISPENSE.
- DISPENSE: first cycle drives grant[owner]=1. motor_on=1 for exactly DISPENSE_CYC cycles. Then go to CHANGE if the change flag is set, else DONE.
- CHANGE: coin_out=1 for exactly CHANGE_CYC cycles, then DONE.
- DONE: done[owner]=1 for one cycle; last←owner. Go to IDLE.
- req/change_req are ignored outside IDLE. Requesters drop req on grant. A req still high at the next IDLE is treated as a new sale.
- change_req bits without the matching req bit are ignored.
- Duration counter width $clog2(max(DISPENSE_CYC,CHANGE_CYC)+1). It loads and counts down, with no wrap.
- motor_on and coin_out are never high together.

## Timing
- Reset values: grant=0, motor_on=0, coin_out=0, busy=0, done=0, state=IDLE, last=NREQ-1 (index 0 has top priority after reset).
- req seen in IDLE at cycle t gives:
  - grant and motor_on first high at t+1
  - motor_on high over t+1..t+DISPENSE_CYC
  - coin_out high over t+DISPENSE_CYC+1..t+DISPENSE_CYC+CHANGE_CYC, if change is owed
  - done one cycle after the last active cycle
- busy is high from grant through the DONE cycle inclusive.
- Minimum grant-to-grant spacing: DISPENSE_CYC+2 cycles without change, DISPENSE_CYC+CHANGE_CYC+2 with change.
- Reset mid-operation: all outputs are 0 at the next edge, no done is issued, and last returns to NREQ-1.
- Simultaneous requests are resolved only by the round-robin pointer. No requester waits more than NREQ-1 foreign sales.

## Structure
- Shared package vend_pkg: state enum (IDLE, DISPENSE, CHANGE, DONE) and default timing constants, reused by sale FSMs and the bench.
- One sub-module, rr_pick: combinational round-robin priority select (req, last → one-hot pick, valid). Everything else is in the top.

## Test plan
All scenarios use NREQ=4, DISPENSE_CYC=8, CHANGE_CYC=4.
- req=0100 for one cycle at cycle 0, no change → grant=0100 at 1, motor_on 1–8, done=0100 at 9, busy 1–9, coin_out never high.
- req=0010, change_req=0010 at 0 → motor_on 1–8, coin_out 9–12, done=0010 at 13.
- req=1111 held from reset release, each bit dropped on its grant → grant order 0001, 0010, 0100, 1000, each 10 cycles apart.
- After a grant to index 2 completes, req=1001 → next grant 1000, then 0001 (wrap).
- Reset at motor cycle 4 → motor_on=0 and busy=0 next cycle, no done. Then req=0011 → grant=0001.
- change_req=0100 with req=0000 for 20 cycles → no grant, busy=0. Change is not applied to a later req[2] unless change_req[2] is high with it.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending definitions: mechanism states and default timing.
// Used by the sale FSMs, the dispense arbiter and the bench.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2,
    DONE     = 2'd3
  } vend_state_e;

  localparam int VEND_NREQ         = 4;
  localparam int VEND_DISPENSE_CYC = 8;
  localparam int VEND_CHANGE_CYC   = 4;

  function automatic int vend_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_dispense_arbiter_rr_pick.sv
// Combinational round-robin select: the first set req bit searching upward
// from last+1 (wrapping), as a one-hot and as an index.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx,
  output logic            valid
);

  int idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    idx      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        pick[idx]   = 1'b1;
        pick_idx    = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Round-robin owner of the shared dispense motor and change chute:
// grant, motor interval, optional change interval, then a done pulse.
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int NREQ         = VEND_NREQ,
  parameter int DISPENSE_CYC = VEND_DISPENSE_CYC,
  parameter int CHANGE_CYC   = VEND_CHANGE_CYC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] change_req,
  output logic [NREQ-1:0] grant,
  output logic            motor_on,
  output logic            coin_out,
  output logic            busy,
  output logic [NREQ-1:0] done
);

  localparam int IW    = $clog2(NREQ);
  localparam int CNT_W = $clog2(vend_max(DISPENSE_CYC, CHANGE_CYC) + 1);

  vend_state_e      state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req      (req),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      chg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from registered state only, so a reset edge clears them all.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    chg_d    = chg_q;
    cnt_d    = cnt_q;
    grant    = '0;
    done     = '0;
    motor_on = 1'b0;
    coin_out = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          chg_d   = change_req[pick_idx];
          cnt_d   = CNT_W'(DISPENSE_CYC - 1);
          state_d = DISPENSE;
        end
      end
      DISPENSE: begin
        motor_on = 1'b1;
        if (cnt_q == CNT_W'(DISPENSE_CYC - 1)) grant[owner_q] = 1'b1;
        if (cnt_q == '0) begin
          if (chg_q) begin
            cnt_d   = CNT_W'(CHANGE_CYC - 1);
            state_d = CHANGE;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CHANGE: begin
        coin_out = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        done[owner_q] = 1'b1;
        last_d        = owner_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Bench for vend_dispense_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a sale-timeline model (grant time + offsets).
module tb_vend_dispense_arbiter;
  import vend_pkg::*;

  localparam int N = 4;
  localparam int D = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, change_req;
  logic [N-1:0] grant, done;
  logic         motor_on, coin_out, busy;

  vend_dispense_arbiter #(.NREQ(N), .DISPENSE_CYC(D), .CHANGE_CYC(C)) dut (
    .clk(clk), .reset(reset), .req(req), .change_req(change_req),
    .grant(grant), .motor_on(motor_on), .coin_out(coin_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // model: a sale is just (owner, change owed, grant cycle); outputs follow from elapsed time
  bit           m_free = 1'b1;
  int           m_owner, m_t0, m_last = N - 1;
  bit           m_chg;
  logic [N-1:0] pend = '0;

  int gv[$], gc[$];
  int ndone = 0, dcyc = -1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    int e, last_e;
    logic [N-1:0] eg, ed;
    req = pend;
    #1;
    e = cyc - m_t0;
    last_e = D + (m_chg ? C : 0);
    eg = (!m_free && e == 0) ? N'(1 << m_owner) : '0;
    ed = (!m_free && e == last_e) ? N'(1 << m_owner) : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("motor_on", 32'(motor_on), 32'(!m_free && e < D));
    chk("coin_out", 32'(coin_out), 32'(!m_free && m_chg && e >= D && e < last_e));
    chk("busy", 32'(busy), 32'(!m_free));
    chk("done", 32'(done), 32'(ed));
    chk("motor_coin_excl", 32'(motor_on & coin_out), 32'd0);
    if (grant != '0) begin gv.push_back(int'(grant)); gc.push_back(cyc); end
    if (done != '0) begin ndone++; dcyc = cyc; end
    if (reset) begin
      m_free = 1'b1;
      m_last = N - 1;
    end else if (m_free) begin
      if (req != '0) begin
        for (int i = 1; i <= N; i++) begin
          if (m_free && req[(m_last + i) % N]) begin
            m_owner = (m_last + i) % N;
            m_free  = 1'b0;
          end
        end
        m_chg = change_req[m_owner];
        m_t0  = cyc + 1;
        pend[m_owner] = 1'b0;
      end
    end else if (e == last_e) begin
      m_last = m_owner;
      m_free = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend  = '0;
    run(2);
    reset = 1'b0;
    gv.delete(); gc.delete();
  endtask

  int c0, nd0;

  initial begin
    reset = 1'b1; req = '0; change_req = '0;
    @(negedge clk);

    // reset state observed under reset
    do_reset();

    // single sale, no change
    c0 = cyc; pend = 4'b0100;
    run(12);
    chk("t1_ngrant", gv.size(), 1);
    if (gv.size() > 0) begin
      chk("t1_grant", gv[0], 4'b0100);
      chk("t1_grant_at", gc[0] - c0, 1);
    end
    chk("t1_done_at", dcyc - c0, 9);

    // single sale with change
    do_reset();
    c0 = cyc; pend = 4'b0010; change_req = 4'b0010;
    run(16);
    change_req = '0;
    chk("t2_done_at", dcyc - c0, 13);

    // all requesting from reset: in order, 10 cycles apart
    do_reset();
    pend = 4'b1111;
    run(45);
    chk("t3_ngrant", gv.size(), 4);
    for (int i = 0; i < 4 && i < gv.size(); i++) begin
      chk("t3_order", gv[i], 1 << i);
      if (i > 0) chk("t3_spacing", gc[i] - gc[i-1], D + 2);
    end

    // wrap after index 2 completes
    do_reset();
    pend = 4'b0100;
    run(12);
    gv.delete(); gc.delete();
    pend = 4'b1001;
    run(25);
    chk("t4_ngrant", gv.size(), 2);
    if (gv.size() == 2) begin
      chk("t4_first", gv[0], 4'b1000);
      chk("t4_second", gv[1], 4'b0001);
    end

    // reset mid motor interval
    do_reset();
    pend = 4'b0100;
    run(4);
    nd0 = ndone;
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    gv.delete(); gc.delete();
    run(1);
    chk("t5_no_done", ndone, nd0);
    pend = 4'b0011;
    run(14);
    if (gv.size() > 0) chk("t5_grant", gv[0], 4'b0001);
    else chk("t5_ngrant", gv.size(), 1);

    // change_req alone never grants, and does not stick to a later sale
    do_reset();
    change_req = 4'b0100;
    run(20);
    chk("t6_ngrant", gv.size(), 0);
    change_req = '0; pend = 4'b0100;
    run(14);

    // random traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      pend       = pend | N'($urandom_range(0, 15) & (($urandom_range(0, 3) == 0) ? 4'hf : 4'h0));
      change_req = N'($urandom_range(0, 15));
      reset      = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
